// File: rtl/ddr_addr_gen_2d_if.sv
// Command and DDR request channels of the 2D address generator.
// master = generator side, slave = scheduler/controller side.
interface ddr_addr_gen_2d_if #(
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 16
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DDR_ADDR_W-1:0] st_addr;
    logic [BURST_W-1:0]    burst;
    logic [DDR_ADDR_W-1:0] step_inner;
    logic [BURST_W-1:0]    num_inner;
    logic [DDR_ADDR_W-1:0] step_outer;
    logic [BURST_W-1:0]    num_outer;
    logic                  done;
    logic [DDR_ADDR_W-1:0] ddr_addr;
    logic [BURST_W-1:0]    ddr_size;
    logic                  ddr_addr_valid;
    logic                  ddr_addr_ready;

    modport master (
        input  cmd_valid, st_addr, burst, step_inner, num_inner, step_outer, num_outer,
        input  ddr_addr_ready,
        output cmd_ready, done, ddr_addr, ddr_size, ddr_addr_valid
    );

    modport slave (
        output cmd_valid, st_addr, burst, step_inner, num_inner, step_outer, num_outer,
        output ddr_addr_ready,
        input  cmd_ready, done, ddr_addr, ddr_size, ddr_addr_valid
    );
endinterface

// File: rtl/ddr_addr_gen_2d.sv
// Two-level strided DDR address generator: one request per burst of an outer x inner grid.
// Latency: first request the cycle after command accept; one request per cycle with ready high.
// Backpressure: request held stable until ddr_addr_ready. Macro DDR_ADDR_GEN_4K_SPLIT_EN splits 4 KB crossings.
module ddr_addr_gen_2d #(
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    ddr_addr_gen_2d_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1
`ifdef DDR_ADDR_GEN_4K_SPLIT_EN
        , SPLIT = 2'd2
`endif
    } state_t;

    state_t state, state_n;

    logic [BURST_W-1:0]    burst_r;
    logic [DDR_ADDR_W-1:0] step_inner_r;
    logic [DDR_ADDR_W-1:0] step_outer_r;
    logic [BURST_W-1:0]    num_inner_r;
    logic [BURST_W-1:0]    num_outer_r;
    logic [DDR_ADDR_W-1:0] row_base;
    logic [DDR_ADDR_W-1:0] addr;
    logic [BURST_W-1:0]    inner_cnt;
    logic [BURST_W-1:0]    outer_cnt;
    logic                  zero_r;

    logic accept;
    logic adv;
    logic inner_more;
    logic outer_more;

    // Counts are nonzero whenever adv can fire, so num-1 never underflows.
    assign inner_more = inner_cnt < (num_inner_r - 1'b1);
    assign outer_more = outer_cnt < (num_outer_r - 1'b1);

`ifdef DDR_ADDR_GEN_4K_SPLIT_EN
    logic                  cross;
    logic [BURST_W-1:0]    first_size;
    logic [DDR_ADDR_W-1:0] split_addr;
    logic [BURST_W-1:0]    split_size;
    logic                  to_split;

    assign cross      = ({5'd0, addr[11:0]} + {1'b0, burst_r}) > 17'd4096;
    assign first_size = BURST_W'(13'd4096 - {1'b0, addr[11:0]});
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n            = state;
        accept             = 1'b0;
        adv                = 1'b0;
        bus.cmd_ready      = 1'b0;
        bus.done           = 1'b0;
        bus.ddr_addr_valid = 1'b0;
        bus.ddr_addr       = addr;
        bus.ddr_size       = burst_r;
`ifdef DDR_ADDR_GEN_4K_SPLIT_EN
        to_split           = 1'b0;
`endif
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.done      = 1'b1;
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (zero_r) begin
                    state_n = IDLE;
                end else begin
                    bus.ddr_addr_valid = 1'b1;
`ifdef DDR_ADDR_GEN_4K_SPLIT_EN
                    if (cross) begin
                        bus.ddr_size = first_size;
                        if (bus.ddr_addr_ready) begin
                            to_split = 1'b1;
                            state_n  = SPLIT;
                        end
                    end else
`endif
                    if (bus.ddr_addr_ready) begin
                        adv = 1'b1;
                        if (!inner_more && !outer_more) state_n = IDLE;
                    end
                end
            end
`ifdef DDR_ADDR_GEN_4K_SPLIT_EN
            SPLIT: begin
                bus.ddr_addr_valid = 1'b1;
                bus.ddr_addr       = split_addr;
                bus.ddr_size       = split_size;
                if (bus.ddr_addr_ready) begin
                    adv     = 1'b1;
                    state_n = (!inner_more && !outer_more) ? IDLE : RUN;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_r      <= '0;
            step_inner_r <= '0;
            step_outer_r <= '0;
            num_inner_r  <= '0;
            num_outer_r  <= '0;
            row_base     <= '0;
            addr         <= '0;
            inner_cnt    <= '0;
            outer_cnt    <= '0;
            zero_r       <= 1'b0;
        end else if (accept) begin
            burst_r      <= bus.burst;
            step_inner_r <= bus.step_inner;
            step_outer_r <= bus.step_outer;
            num_inner_r  <= bus.num_inner;
            num_outer_r  <= bus.num_outer;
            row_base     <= bus.st_addr;
            addr         <= bus.st_addr;
            inner_cnt    <= '0;
            outer_cnt    <= '0;
            zero_r       <= (bus.num_inner == '0) || (bus.num_outer == '0);
        end else if (adv) begin
            if (inner_more) begin
                addr      <= addr + step_inner_r;
                inner_cnt <= inner_cnt + 1'b1;
            end else if (outer_more) begin
                row_base  <= row_base + step_outer_r;
                addr      <= row_base + step_outer_r;
                inner_cnt <= '0;
                outer_cnt <= outer_cnt + 1'b1;
            end
        end
    end

`ifdef DDR_ADDR_GEN_4K_SPLIT_EN
    // Second half of a crossing burst starts on the next 4 KB page.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            split_addr <= '0;
            split_size <= '0;
        end else if (to_split) begin
            split_addr <= {addr[DDR_ADDR_W-1:12], 12'd0} + DDR_ADDR_W'(4096);
            split_size <= burst_r - first_size;
        end
    end
`endif
endmodule

// File: tb/tb_ddr_addr_gen_2d.sv
// Directed bench for ddr_addr_gen_2d: inputs driven and outputs sampled on the falling edge.
module tb_ddr_addr_gen_2d;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ddr_addr_gen_2d_if #(.DDR_ADDR_W(32), .BURST_W(16)) bus ();

    ddr_addr_gen_2d #(.DDR_ADDR_W(32), .BURST_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    logic [31:0] grid_exp [6] = '{32'h1000, 32'h1040, 32'h1080, 32'h1400, 32'h1440, 32'h1480};

    task automatic send_cmd(input logic [31:0] a, input logic [15:0] b, input logic [31:0] si,
                            input logic [15:0] ni, input logic [31:0] so, input logic [15:0] no);
        bus.st_addr    = a;
        bus.burst      = b;
        bus.step_inner = si;
        bus.num_inner  = ni;
        bus.step_outer = so;
        bus.num_outer  = no;
        bus.cmd_valid  = 1'b1;
        tests++;
        if (bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.ddr_addr_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size, bus.cmd_ready, bus.done} !== {1'b0, 32'h0, 16'h0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL reset: valid=%b addr=%h size=%0d rdy=%b done=%b required 0 0 0 1 1",
                     bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size, bus.cmd_ready, bus.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        bus.ddr_addr_ready = 1'b1;
        send_cmd(32'h100, 16'd64, 32'h0, 16'd1, 32'h0, 16'd1);
        tests++;
        if ({bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size, bus.done} !== {1'b1, 32'h100, 16'd64, 1'b0}) begin
            fails++;
            $display("FAIL single_req: valid=%b addr=%h size=%0d done=%b required 1 100 64 0",
                     bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size, bus.done);
        end
        @(negedge clk);
        tests++;
        if ({bus.ddr_addr_valid, bus.done, bus.cmd_ready} !== 3'b011) begin
            fails++;
            $display("FAIL single_done: valid=%b done=%b rdy=%b required 0 1 1",
                     bus.ddr_addr_valid, bus.done, bus.cmd_ready);
        end
    endtask

    task automatic test_grid;
        bus.ddr_addr_ready = 1'b1;
        send_cmd(32'h1000, 16'd64, 32'h40, 16'd3, 32'h400, 16'd2);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if ({bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size} !== {1'b1, grid_exp[i], 16'd64}) begin
                fails++;
                $display("FAIL grid_req%0d: valid=%b addr=%h size=%0d required 1 %h 64",
                         i, bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size, grid_exp[i]);
            end
            @(negedge clk);
        end
        tests++;
        if ({bus.ddr_addr_valid, bus.done} !== 2'b01) begin
            fails++;
            $display("FAIL grid_done: valid=%b done=%b required 0 1", bus.ddr_addr_valid, bus.done);
        end
    endtask

    task automatic test_back_to_back;
        // Starts on the completion cycle left by test_grid.
        send_cmd(32'h7000, 16'd32, 32'h0, 16'd1, 32'h0, 16'd1);
        tests++;
        if ({bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size} !== {1'b1, 32'h7000, 16'd32}) begin
            fails++;
            $display("FAIL b2b_req: valid=%b addr=%h size=%0d required 1 7000 32",
                     bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int idx = 0;
        int budget = 200;
        send_cmd(32'h1000, 16'd64, 32'h40, 16'd3, 32'h400, 16'd2);
        while (idx < 6 && budget > 0) begin
            bus.ddr_addr_ready = 1'($urandom_range(0, 1));
            tests++;
            if ({bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size} !== {1'b1, grid_exp[idx], 16'd64}) begin
                fails++;
                $display("FAIL bp_req%0d: valid=%b addr=%h size=%0d required 1 %h 64",
                         idx, bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size, grid_exp[idx]);
            end
            if (bus.ddr_addr_ready) idx++;
            budget--;
            @(negedge clk);
        end
        tests++;
        if (idx != 6 || bus.ddr_addr_valid !== 1'b0 || bus.done !== 1'b1) begin
            fails++;
            $display("FAIL bp_done: handshakes=%0d valid=%b done=%b required 6 0 1",
                     idx, bus.ddr_addr_valid, bus.done);
        end
        bus.ddr_addr_ready = 1'b1;
    endtask

    task automatic test_zero;
        bus.ddr_addr_ready = 1'b1;
        send_cmd(32'h2000, 16'd64, 32'h40, 16'd0, 32'h100, 16'd2);
        tests++;
        if ({bus.ddr_addr_valid, bus.cmd_ready, bus.done} !== 3'b000) begin
            fails++;
            $display("FAIL zero_run: valid=%b rdy=%b done=%b required 0 0 0",
                     bus.ddr_addr_valid, bus.cmd_ready, bus.done);
        end
        bus.st_addr   = 32'h5000;
        bus.num_inner = 16'd1;
        bus.num_outer = 16'd1;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        tests++;
        if ({bus.ddr_addr_valid, bus.done} !== 2'b01) begin
            fails++;
            $display("FAIL zero_done: valid=%b done=%b required 0 1", bus.ddr_addr_valid, bus.done);
        end
        @(negedge clk);
        tests++;
        if ({bus.ddr_addr_valid, bus.done} !== 2'b01) begin
            fails++;
            $display("FAIL zero_ignored_cmd: valid=%b done=%b required 0 1", bus.ddr_addr_valid, bus.done);
        end
    endtask

    task automatic test_split;
        bus.ddr_addr_ready = 1'b1;
        send_cmd(32'h0FC0, 16'd128, 32'h0, 16'd1, 32'h0, 16'd1);
`ifdef DDR_ADDR_GEN_4K_SPLIT_EN
        tests++;
        if ({bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size} !== {1'b1, 32'h0FC0, 16'd64}) begin
            fails++;
            $display("FAIL split_first: valid=%b addr=%h size=%0d required 1 0fc0 64",
                     bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size);
        end
        @(negedge clk);
        tests++;
        if ({bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size} !== {1'b1, 32'h1000, 16'd64}) begin
            fails++;
            $display("FAIL split_second: valid=%b addr=%h size=%0d required 1 1000 64",
                     bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size);
        end
`else
        tests++;
        if ({bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size} !== {1'b1, 32'h0FC0, 16'd128}) begin
            fails++;
            $display("FAIL nosplit_req: valid=%b addr=%h size=%0d required 1 0fc0 128",
                     bus.ddr_addr_valid, bus.ddr_addr, bus.ddr_size);
        end
`endif
        @(negedge clk);
        tests++;
        if ({bus.ddr_addr_valid, bus.done} !== 2'b01) begin
            fails++;
            $display("FAIL split_done: valid=%b done=%b required 0 1", bus.ddr_addr_valid, bus.done);
        end
    endtask

    task automatic test_reset_mid;
        bus.ddr_addr_ready = 1'b1;
        send_cmd(32'h1000, 16'd64, 32'h40, 16'd3, 32'h400, 16'd2);
        repeat (2) @(negedge clk);
        tests++;
        if (bus.ddr_addr !== 32'h1080) begin
            fails++;
            $display("FAIL rstmid_third: addr=%h required 1080", bus.ddr_addr);
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.ddr_addr_valid, bus.done, bus.ddr_addr} !== {1'b0, 1'b1, 32'h0}) begin
            fails++;
            $display("FAIL rstmid_state: valid=%b done=%b addr=%h required 0 1 0",
                     bus.ddr_addr_valid, bus.done, bus.ddr_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_cmd(32'h3000, 16'd32, 32'h20, 16'd2, 32'h0, 16'd1);
        tests++;
        if ({bus.ddr_addr_valid, bus.ddr_addr} !== {1'b1, 32'h3000}) begin
            fails++;
            $display("FAIL rstmid_new0: valid=%b addr=%h required 1 3000", bus.ddr_addr_valid, bus.ddr_addr);
        end
        @(negedge clk);
        tests++;
        if ({bus.ddr_addr_valid, bus.ddr_addr} !== {1'b1, 32'h3020}) begin
            fails++;
            $display("FAIL rstmid_new1: valid=%b addr=%h required 1 3020", bus.ddr_addr_valid, bus.ddr_addr);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.cmd_valid      = 1'b0;
        bus.st_addr        = '0;
        bus.burst          = '0;
        bus.step_inner     = '0;
        bus.num_inner      = '0;
        bus.step_outer     = '0;
        bus.num_outer      = '0;
        bus.ddr_addr_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_single;
        test_grid;
        test_back_to_back;
        test_backpressure;
        test_zero;
        test_split;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
